// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch front end: FSM states, next-PC select codes, reset vector.
package mips_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HALT  = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      SEL_SEQ = 2'd0,
      SEL_BR  = 2'd1,
      SEL_J   = 2'd2,
      SEL_JR  = 2'd3
   } pc_sel_e;

   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC candidates (sequential, branch, jump) and the prioritised select code.
module pc_target_calc
   import mips_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic              branch,
   input  logic              zero,
   input  logic              jump,
   input  logic              jr,
   input  logic [ADDR_W-1:0] imm_ext,
   input  logic [25:0]       instr_index,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic [ADDR_W-1:0] br_target,
   output logic [ADDR_W-1:0] j_target,
   output pc_sel_e           sel
);

   logic [ADDR_W-1:0] offset_s;

   shiftleft2 u_shl2 (
      .a (imm_ext),
      .y (offset_s)
   );

   assign pc_plus4  = pc + 32'd4;
   assign br_target = pc_plus4 + offset_s;
   assign j_target  = {pc_plus4[ADDR_W-1:ADDR_W-4], instr_index, 2'b00};

   // Priority: jr over jump over taken branch over sequential.
   always_comb begin
      sel = SEL_SEQ;
      if (jr) begin
         sel = SEL_JR;
      end else if (jump) begin
         sel = SEL_J;
      end else if (branch && zero) begin
         sel = SEL_BR;
      end else begin
         sel = SEL_SEQ;
      end
   end

endmodule

// File: rtl/shiftleft2.sv
// Word-offset scaling: shifts a 32-bit value left by two, dropping the top bits.
module shiftleft2 (
   input  logic [31:0] a,
   output logic [31:0] y
);

   assign y = {a[29:0], 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and fetch handshake for the MIPS core.
// Optional delay-slot behaviour is enabled by defining DELAY_SLOT_EN.
module pc_sequencer
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter int          ADDR_W       = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              fetch_ready,
   input  logic              branch,
   input  logic              zero,
   input  logic              jump,
   input  logic              jr,
   input  logic [ADDR_W-1:0] imm_ext,
   input  logic [25:0]       instr_index,
   input  logic [ADDR_W-1:0] rs_val,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic              fetch_valid,
   output logic              redirect,
   output logic              misalign_err
);

   logic [ADDR_W-1:0] pc_plus4_s;
   logic [ADDR_W-1:0] br_target_s;
   logic [ADDR_W-1:0] j_target_s;
   logic [ADDR_W-1:0] target_s;
   pc_sel_e           sel_s;
   logic              accept_s;
   logic              misalign_s;

   state_e            state_r;
   logic [ADDR_W-1:0] pc_r;
   logic              fetch_valid_r;
   logic              redirect_r;
   logic              misalign_err_r;
`ifdef DELAY_SLOT_EN
   logic              pending_r;
   logic [ADDR_W-1:0] pending_target_r;
`endif

   pc_target_calc #(.ADDR_W(ADDR_W)) u_calc (
      .pc          (pc_r),
      .branch      (branch),
      .zero        (zero),
      .jump        (jump),
      .jr          (jr),
      .imm_ext     (imm_ext),
      .instr_index (instr_index),
      .pc_plus4    (pc_plus4_s),
      .br_target   (br_target_s),
      .j_target    (j_target_s),
      .sel         (sel_s)
   );

   assign accept_s   = fetch_valid_r & fetch_ready & ~stall;
   assign misalign_s = (sel_s == SEL_JR) && (rs_val[1:0] != 2'b00);

   // Next-PC mux driven by the prioritised select code.
   always_comb begin
      target_s = pc_plus4_s;
      case (sel_s)
         SEL_JR:  target_s = rs_val;
         SEL_J:   target_s = j_target_s;
         SEL_BR:  target_s = br_target_s;
         SEL_SEQ: target_s = pc_plus4_s;
         default: target_s = pc_plus4_s;
      endcase
   end

   // Sequencer FSM, PC register and status flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r          <= IDLE;
         pc_r             <= RESET_VECTOR;
         fetch_valid_r    <= 1'b0;
         redirect_r       <= 1'b0;
         misalign_err_r   <= 1'b0;
`ifdef DELAY_SLOT_EN
         pending_r        <= 1'b0;
         pending_target_r <= RESET_VECTOR;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               state_r       <= FETCH;
               fetch_valid_r <= 1'b1;
               redirect_r    <= 1'b0;
            end
            FETCH: begin
               if (accept_s) begin
`ifdef DELAY_SLOT_EN
                  // Delay-slot accept ignores the control inputs entirely.
                  if (pending_r) begin
                     pc_r       <= pending_target_r;
                     redirect_r <= 1'b1;
                     pending_r  <= 1'b0;
                  end else if (misalign_s) begin
                     misalign_err_r <= 1'b1;
                     state_r        <= HALT;
                     fetch_valid_r  <= 1'b0;
                     redirect_r     <= 1'b0;
                  end else if (sel_s != SEL_SEQ) begin
                     pc_r             <= pc_plus4_s;
                     pending_target_r <= target_s;
                     pending_r        <= 1'b1;
                     redirect_r       <= 1'b0;
                  end else begin
                     pc_r       <= pc_plus4_s;
                     redirect_r <= 1'b0;
                  end
`else
                  if (misalign_s) begin
                     misalign_err_r <= 1'b1;
                     state_r        <= HALT;
                     fetch_valid_r  <= 1'b0;
                     redirect_r     <= 1'b0;
                  end else begin
                     pc_r       <= target_s;
                     redirect_r <= (sel_s != SEL_SEQ);
                  end
`endif
               end else begin
                  redirect_r <= 1'b0;
               end
            end
            HALT: begin
               fetch_valid_r <= 1'b0;
               redirect_r    <= 1'b0;
            end
            default: begin
               state_r       <= IDLE;
               fetch_valid_r <= 1'b0;
               redirect_r    <= 1'b0;
            end
         endcase
      end
   end

   assign pc           = pc_r;
   assign pc_plus4     = pc_plus4_s;
   assign fetch_valid  = fetch_valid_r;
   assign redirect     = redirect_r;
   assign misalign_err = misalign_err_r;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter and computes the next-PC target for the MIPS core.
- Sequences the branch-offset path: sign-extended immediate shifted left by 2, then added to PC+4.
- Supports the jump target, the jr target and sequential PC+4.
- Presents the current PC to instruction fetch over a valid/ready handshake, and holds it under pipeline stall.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC/address width (only 32 is supported).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard stall; holds PC.
- fetch_ready  in  1  instruction memory accepts the current PC.
- branch  in  1  current instruction is a conditional branch.
- zero  in  1  ALU zero flag; branch is taken when branch & zero.
- jump  in  1  current instruction is j/jal.
- jr  in  1  current instruction is jr.
- imm_ext  in  32  sign-extended 16-bit immediate.
- instr_index  in  26  jump index field.
- rs_val  in  32  register value for jr.
- pc  out  32  current PC.
- pc_plus4  out  32  pc + 4 (combinational from pc).
- fetch_valid  out  1  pc is valid for fetch.
- redirect  out  1  one-cycle pulse after a non-sequential PC load.
- misalign_err  out  1  sticky: jr target not word-aligned.

Behaviour:
- Reset values: pc=RESET_VECTOR, fetch_valid=0, redirect=0, misalign_err=0, state=IDLE.
- Reset applies on any clock edge with reset=1, including in HALT and with a pending delay-slot target.
- FSM states: IDLE, FETCH, HALT.
  - IDLE -> FETCH unconditionally on the first clock after reset deasserts. fetch_valid=0 in IDLE.
  - In FETCH, fetch_valid=1.
  - Accept cycle is defined as fetch_valid & fetch_ready & ~stall.
  - Control inputs (branch, zero, jump, jr, imm_ext, instr_index, rs_val) are sampled only in an accept cycle.
  - In non-accept cycles, pc holds and fetch_valid stays 1.
- Target arithmetic (all mod 2^32; carries out of bit 31 are dropped):
  - branch target = pc_plus4 + (imm_ext << 2).
  - jump target = {pc_plus4[31:28], instr_index, 2'b00}.
  - jr target = rs_val.
- Selection priority on accept: jr > jump > (branch & zero) > pc_plus4.
- On accept, pc <= the selected value.
- redirect is 1 in the cycle following an accept that loaded a non-sequential target; otherwise 0.
- Misaligned jr: if jr is accepted with rs_val[1:0] != 0:
  - pc holds.
  - misalign_err <= 1.
  - state -> HALT.
- HALT:
  - fetch_valid=0.
  - pc frozen.
  - misalign_err stays 1.
  - Exit only by reset.
- stall=1 overrides fetch_ready=1: no PC update.
- pc wrap-around: 32'hFFFF_FFFC + 4 gives 32'h0000_0000, with no error.

Optional Feature:
- Macro: DELAY_SLOT_EN.
- Defined:
  - On an accept that selects a non-sequential target, pc <= pc_plus4 and the target is latched in pending_target (pending=1).
  - The next accept loads pc <= pending_target, pulses redirect, and clears pending.
  - Control inputs on that delay-slot accept are ignored, including jr misalignment checks.
  - Reset clears pending.
- Undefined:
  - Targets are taken immediately as described above.
  - No pending register exists.

Decomposition:
- Shared package mips_pkg holds:
  - the state enum (IDLE, FETCH, HALT);
  - the 2-bit next-PC select encoding (SEL_SEQ, SEL_BR, SEL_J, SEL_JR);
  - the default reset vector constant.
- One combinational sub-module, pc_target_calc, produces pc_plus4, the branch target, the jump target and the select code. It uses the existing shiftleft2 module for the offset.
- FSM, pc register and delay-slot logic stay in pc_sequencer.

Test Plan:
1. Reset sequence:
   - Stimulus: reset high 2 cycles, then low; fetch_ready=1, stall=0, no control inputs.
   - Response: pc=0, fetch_valid=0 for one cycle, then pc = 0, 4, 8, … each cycle.
2. Taken branch:
   - Stimulus: at pc=0x10, accept with branch=1, zero=1, imm_ext=0xFFFF_FFFE.
   - Response: next pc=0x0C, redirect=1 for one cycle.
   - Repeat with zero=0: next pc=0x14, redirect stays 0.
3. Jump and priority:
   - Stimulus: at pc=0x4000_0010, jump=1 with instr_index=0x0000100.
   - Response: next pc=0x4000_0400.
   - Stimulus: jr=1, jump=1, rs_val=0x80.
   - Response: pc=0x80 (jr wins).
4. Stall and backpressure:
   - Stimulus: stall=1 for 3 cycles, then fetch_ready=0 for 2 cycles, while branch=1, zero=1.
   - Response: pc unchanged and fetch_valid=1 throughout.
   - Stimulus: first accept after release.
   - Response: takes the branch.
5. Misaligned jr:
   - Stimulus: rs_val=0x0000_0102 with jr=1.
   - Response: misalign_err=1, fetch_valid=0, pc frozen for 5+ cycles.
   - Stimulus: reset.
   - Response: clears the error, pc=RESET_VECTOR.
6. DELAY_SLOT_EN build:
   - Stimulus: at pc=0x20, accept with jump=1, instr_index=0x40.
   - Response: pc goes 0x24, then 0x100; redirect pulses after the 0x100 load.
   - Stimulus: reset asserted while pending.
   - Response: pending discarded, pc=RESET_VECTOR.
